// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// start/done handshake; results held until the next completion.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   sh;
  logic [WIDTH:0]   diff;
  logic             neg;
  logic [WIDTH-1:0] q_nx;
  logic [WIDTH-1:0] r_nx;
  logic             last;

  // The shifted remainder is below 2*D, so a WIDTH+1 bit
  // difference is enough to read the sign from its MSB.
  always_comb begin
    sh   = {r_q, q_q[WIDTH-1]};
    diff = sh - {1'b0, d_q};
    neg  = diff[WIDTH];
    q_nx = {q_q[WIDTH-2:0], ~neg};
    r_nx = neg ? sh[WIDTH-1:0] : diff[WIDTH-1:0];
    last = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          q_d    = dividend;
          d_d    = divisor;
          r_d    = '0;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      CALC: begin
        q_d   = q_nx;
        r_d   = r_nx;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          busy_d  = 1'b0;
          quo_d   = q_nx;
          rem_d   = r_nx;
          dbz_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed table, handshake corner
// cases and a random sweep against a plain-arithmetic model.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
  } vec_t;

  vec_t tbl[8];

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model(input int a, input int b,
                                output int q, output int r,
                                output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  task automatic run_op(input int a, input int b, input int eq,
                        input int er, input int ez,
                        input string tag);
    int lat;
    int bcnt;
    @(negedge clk);
    start = 1'b1;
    dividend = W'(a);
    divisor = W'(b);
    @(negedge clk);
    start = 1'b0;
    bcnt = 0;
    for (lat = 1; lat <= 40; lat++) begin
      if (busy) bcnt++;
      if (done) break;
      @(negedge clk);
    end
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " lat"}, lat, (b == 0) ? 1 : W + 1);
    chk({tag, " busycyc"}, bcnt, (b == 0) ? 1 : W);
    chk({tag, " quo"}, int'(quotient), eq);
    chk({tag, " rem"}, int'(remainder), er);
    chk({tag, " dbz"}, int'(div_by_zero), ez);
    @(negedge clk);
    chk({tag, " done1cyc"}, int'(done), 0);
  endtask

  initial begin
    int cyc;
    int t1;
    int t2;
    int nd;
    int qs;
    int rs;
    int base;
    int eq;
    int er;
    int ez;
    int a;
    int b;

    tbl[0] = '{200, 7, 28, 4, 0};
    tbl[1] = '{255, 1, 255, 0, 0};
    tbl[2] = '{5, 9, 0, 5, 0};
    tbl[3] = '{255, 255, 1, 0, 0};
    tbl[4] = '{100, 0, 255, 100, 1};
    tbl[5] = '{9, 3, 3, 0, 0};
    tbl[6] = '{0, 5, 0, 0, 0};
    tbl[7] = '{254, 2, 127, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst quo", int'(quotient), 0);
    chk("rst rem", int'(remainder), 0);
    chk("rst dbz", int'(div_by_zero), 0);
    start = 1'b1;
    dividend = 8'd10;
    divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post-rst done", int'(done), 0);
    chk("post-rst busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
             tbl[i].z, $sformatf("tbl%0d", i));
    end

    // start while busy must be ignored
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    qs = -1;
    rs = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        nd++;
        qs = int'(quotient);
        rs = int'(remainder);
      end
      @(negedge clk);
    end
    chk("ign ndone", nd, 1);
    chk("ign quo", qs, 28);
    chk("ign rem", rs, 4);

    // back-to-back: start accepted in the done cycle
    cyc = 0;
    t1 = -1;
    t2 = -1;
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        if (t1 < 0) begin
          t1 = cyc;
          start = 1'b1;
          dividend = 8'd81;
          divisor = 8'd9;
        end else begin
          t2 = cyc;
          break;
        end
      end else if (t1 >= 0 && cyc == t1 + 2) begin
        chk("b2b busy", int'(busy), 1);
        chk("b2b hold quo", int'(quotient), 28);
        chk("b2b hold rem", int'(remainder), 4);
      end
    end
    chk("b2b gap", t2 - t1, 9);
    chk("b2b quo", int'(quotient), 9);
    chk("b2b rem", int'(remainder), 0);
    @(negedge clk);
    chk("b2b done1cyc", int'(done), 0);

    // asynchronous reset mid-calculation
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd200;
    divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", int'(busy), 0);
    chk("arst done", int'(done), 0);
    chk("arst quo", int'(quotient), 0);
    chk("arst rem", int'(remainder), 0);
    chk("arst dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("arst no done", nd, 0);
    run_op(13, 4, 3, 1, 0, "arst fresh");

    // random sweep against the model
    base = done_cnt;
    for (int i = 0; i < 2000; i++) begin
      a = int'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) b = 0;
      else b = int'($urandom_range(0, 255));
      model(a, b, eq, er, ez);
      run_op(a, b, eq, er, ez, $sformatf("rnd %0d/%0d", a, b));
    end
    @(negedge clk);
    chk("rnd done count", done_cnt - base, 2000);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
